// File: rtl/uart_mem_loader.sv
// uart_mem_loader: receives 8N1 UART bytes, assembles 8-byte big-endian (address, data)
// frames and issues single-word writes on a memory port with a hold-until-grant handshake.
module uart_mem_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT      = 65535,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    output logic [29:0]      mem_addr,
    output logic [31:0]      mem_din,
    output logic             mem_en,
    output logic             mem_we,
    input  logic             mem_gnt,
    output logic             loading,
    output logic [CNT_W-1:0] words_written,
    output logic             err_frame,
    output logic             err_overrun,
    input  logic             clr_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           r_state, w_next;
    logic             r_rx_s1, r_rx_s2, r_armed;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_bit, r_idx;
    logic [7:0]       r_byte;
    logic [55:0]      r_asm;
    logic [TW-1:0]    r_to;
    logic [29:0]      r_addr;
    logic [31:0]      r_din;
    logic             r_en, r_ferr, r_oerr;
    logic [CNT_W-1:0] r_words;
    logic             w_rx, w_tick, w_half, w_byte_valid, w_ferr, w_to, w_done, w_load;

    assign w_rx   = r_rx_s2;
    assign w_tick = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign w_half = r_cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign w_to   = r_to == TW'(TIMEOUT);
    assign w_done = w_byte_valid && r_idx == 3'd7;
    assign w_load = w_done && !r_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_byte_valid = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            IDLE:  w_next = (!w_rx && r_armed) ? START : IDLE;
            START: w_next = w_half ? (w_rx ? IDLE : DATA) : START;
            DATA:  w_next = (w_tick && r_bit == 3'd7) ? STOP : DATA;
            STOP: begin
                w_next       = w_tick ? IDLE : STOP;
                w_byte_valid = w_tick && w_rx;
                w_ferr       = w_tick && !w_rx;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_armed <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_idx   <= '0;
            r_asm   <= '0;
            r_to    <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_en    <= 1'b0;
            r_words <= '0;
            r_ferr  <= 1'b0;
            r_oerr  <= 1'b0;
        end else begin
            r_rx_s1 <= rxd;
            r_rx_s2 <= r_rx_s1;
            // After a framing error the line must return high before a new start bit counts
            r_armed <= w_ferr ? 1'b0 : (w_rx ? 1'b1 : r_armed);
            r_cnt   <= (r_state == IDLE || w_next != r_state || w_tick) ? '0 : r_cnt + 1'b1;
            r_bit   <= (r_state != DATA) ? '0 : (w_tick ? r_bit + 1'b1 : r_bit);
            r_byte  <= (r_state == DATA && w_tick) ? {w_rx, r_byte[7:1]} : r_byte;
            r_idx   <= (w_ferr || w_to) ? '0 : (w_byte_valid ? r_idx + 1'b1 : r_idx);
            r_asm   <= w_byte_valid ? {r_asm[47:0], r_byte} : r_asm;
            r_to    <= (r_idx == 3'd0 || w_byte_valid || w_to) ? '0 :
                       (r_state == IDLE ? r_to + 1'b1 : r_to);
            r_addr  <= w_load ? r_asm[55:26] : r_addr;
            r_din   <= w_load ? {r_asm[23:0], r_byte} : r_din;
            r_en    <= w_load ? 1'b1 : ((r_en && mem_gnt) ? 1'b0 : r_en);
            r_words <= (r_en && mem_gnt) ? r_words + 1'b1 : r_words;
            r_ferr  <= w_ferr ? 1'b1 : (clr_err ? 1'b0 : r_ferr);
            r_oerr  <= (w_done && r_en) ? 1'b1 : (clr_err ? 1'b0 : r_oerr);
        end
    end

    assign mem_addr      = r_addr;
    assign mem_din       = r_din;
    assign mem_en        = r_en;
    assign mem_we        = r_en;
    assign words_written = r_words;
    assign err_frame     = r_ferr;
    assign err_overrun   = r_oerr;
    assign loading       = (r_idx != 3'd0) || (r_state != IDLE) || r_en;
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: drives UART frames into uart_mem_loader and scores each accepted
// memory write against a queue of expected (address, data) pairs.
module tb_uart_mem_loader;
    localparam int CPB = 16;

    logic        clk = 1'b0, rst = 1'b0, rxd = 1'b1, mem_gnt = 1'b0, clr_err = 1'b0;
    logic [29:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_en, mem_we, loading, err_frame, err_overrun;
    logic [15:0] words_written;

    logic [61:0] sb[$];
    int          n_cmp = 0, n_err = 0, writes = 0;
    logic        pend = 1'b0, load_after = 1'b1, en_after = 1'b1;

    uart_mem_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT(200), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_en(mem_en), .mem_we(mem_we), .mem_gnt(mem_gnt), .loading(loading),
        .words_written(words_written), .err_frame(err_frame), .err_overrun(err_overrun),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop;
        tick(CPB);
        rxd = 1'b1;
        tick(4);
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] d);
        logic [63:0] f;
        f = {a, d};
        for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8], 1'b1);
    endtask

    // Any accepted write must match the oldest expected frame
    always @(negedge clk) begin
        if (rst) begin
            if (pend) begin
                load_after = loading;
                en_after   = mem_en;
                pend       = 1'b0;
            end
            if (mem_en && mem_gnt) begin
                logic [61:0] e;
                writes++;
                if (sb.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("wr_addr", mem_addr, e[61:32]);
                    chk("wr_din", mem_din, e[31:0]);
                end
                pend = 1'b1;
            end
        end
    end

    initial begin
        tick(3);
        chk("rst_en", mem_en, 0);
        chk("rst_loading", loading, 0);
        chk("rst_words", words_written, 0);
        chk("rst_addr", mem_addr, 0);
        rst = 1'b1;
        tick(5);

        // single frame with grant held high
        mem_gnt = 1'b1;
        sb.push_back({30'h0000401, 32'hDEADBEEF});
        send_frame(32'h00001004, 32'hDEADBEEF);
        tick(5);
        chk("t1_writes", writes, 1);
        chk("t1_words", words_written, 1);
        chk("t1_load_after", load_after, 0);
        chk("t1_en_after", en_after, 0);
        chk("t1_sb", sb.size(), 0);

        // stalled grant
        mem_gnt = 1'b0;
        sb.push_back({30'h0000040, 32'hCAFEF00D});
        send_frame(32'h00000100, 32'hCAFEF00D);
        for (int i = 0; i < 20; i++) begin
            chk("t2_en", mem_en, 1);
            chk("t2_we", mem_we, mem_en);
            chk("t2_addr", mem_addr, 30'h0000040);
            chk("t2_din", mem_din, 32'hCAFEF00D);
            chk("t2_words_hold", words_written, 1);
            tick(1);
        end
        mem_gnt = 1'b1;
        tick(2);
        chk("t2_words", words_written, 2);
        chk("t2_en_off", mem_en, 0);
        chk("t2_we_off", mem_we, 0);

        // framing error then valid frame
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b0);
        chk("t3_err_frame", err_frame, 1);
        chk("t3_no_write", words_written, 2);
        sb.push_back({30'h0000002, 32'h12345678});
        send_frame(32'h00000008, 32'h12345678);
        tick(3);
        chk("t3_words", words_written, 3);
        chk("t3_err_sticky", err_frame, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t3_err_clr", err_frame, 0);

        // partial frame times out
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1);
        chk("t4_loading_mid", loading, 1);
        tick(250);
        chk("t4_loading_idle1", loading, 0);
        tick(50);
        chk("t4_loading_idle2", loading, 0);
        sb.push_back({30'h0000003, 32'h00000001});
        send_frame(32'h0000000C, 32'h00000001);
        tick(3);
        chk("t4_words", words_written, 4);
        chk("t4_err_frame", err_frame, 0);
        chk("t4_err_overrun", err_overrun, 0);

        // overrun
        mem_gnt = 1'b0;
        sb.push_back({30'h0000010, 32'h11111111});
        send_frame(32'h00000040, 32'h11111111);
        send_frame(32'h00000080, 32'h22222222);
        chk("t5_overrun", err_overrun, 1);
        chk("t5_en", mem_en, 1);
        chk("t5_addr", mem_addr, 30'h0000010);
        chk("t5_din", mem_din, 32'h11111111);
        mem_gnt = 1'b1;
        tick(2);
        chk("t5_words", words_written, 5);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t5_overrun_clr", err_overrun, 0);

        // glitch on rxd
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(20);
        chk("t6_glitch_loading", loading, 0);
        chk("t6_glitch_words", words_written, 5);

        // reset in the middle of byte 6
        for (int i = 0; i < 5; i++) send_byte(8'h55, 1'b1);
        rxd = 1'b0;
        tick(CPB + 3 * CPB);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_words", words_written, 0);
        chk("t6_rst_loading", loading, 0);
        chk("t6_rst_en", mem_en, 0);
        chk("t6_rst_din", mem_din, 0);
        rxd = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(5);
        sb.push_back({30'h0000080, 32'hA5A5A5A5});
        send_frame(32'h00000200, 32'hA5A5A5A5);
        tick(3);
        chk("t6_words", words_written, 1);
        chk("t6_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
